fifo_rd_port: RTL and testbench

//  Read-side front end for a FIFO built from fifo_ctrl plus a synchronous-read memory (1-cycle read latency).

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_skid_buf.sv | 73 +++++++
 rtl/fifo_rd_port.sv | 73 +++++++
 tb/tb_fifo_rd_port.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-port front end.
// Also holds the helper that counts words already committed to the skid buffer.
package fifo_rd_pkg;

  localparam int SKID_DEP = 2;
  localparam int OCC_W    = 2;

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_FULL = 2'd2;

  // Words held in the skid buffer plus the one still in flight from memory.
  function automatic logic [2:0] pending(input occ_t occ, input logic infl);
    return {1'b0, occ} + {2'b00, infl};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register queue with push/pop/clear.
// Exposes the head word, the occupancy and a registered valid flag.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                clr_i,
  input  logic [DATA_WID-1:0] din_i,
  output logic [DATA_WID-1:0] head_o,
  output occ_t                occ_o,
  output logic                vld_o
);

  occ_t                occ_q, occ_d;
  logic [DATA_WID-1:0] head_q, head_d;
  logic [DATA_WID-1:0] tail_q, tail_d;
  logic                vld_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (clr_i) begin
      occ_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == '0) head_d = din_i;
          else             tail_d = din_i;
          occ_d = occ_q + 1'b1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 1'b1;
        end
        2'b11: begin
          // Head leaves and the new word joins behind whatever remains.
          if (occ_q == OCC_FULL) begin
            head_d = tail_q;
            tail_d = din_i;
          end else begin
            head_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      vld_q  <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      vld_q  <= (occ_d != '0);
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_o = head_q;
  assign occ_o  = occ_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side front end: issues memory reads, absorbs read latency in a skid buffer, streams valid/ready.
// Optional accepted-word counter on pop_cnt when FIFO_RD_STATS_EN is defined.
module fifo_rd_port
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  output logic                fifo_oen,
  input  logic [DATA_WID-1:0] mem_rdata,
  input  logic                flush,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [DATA_WID-1:0] out_dat
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]         pop_cnt
`endif
);

  logic infl_q, infl_d;
  occ_t occ;
  logic vld;
  logic pop, issue, push;

  assign pop = vld & out_rdy;

  // A pop this cycle frees a slot, so a read may be issued even when full.
  assign issue = rst_n & ~fifo_empty & ~flush &
                 ((pending(occ, infl_q) < 3'(SKID_DEP)) | pop);

  assign infl_d   = issue;
  assign push     = infl_q & ~flush;
  assign fifo_oen = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) infl_q <= 1'b0;
    else        infl_q <= infl_d;
  end

  fifo_skid_buf #(
    .DATA_WID (DATA_WID)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .clr_i  (flush),
    .din_i  (mem_rdata),
    .head_o (out_dat),
    .occ_o  (occ),
    .vld_o  (vld)
  );

  assign out_vld = vld;

`ifdef FIFO_RD_STATS_EN
  logic [31:0] pop_cnt_q, pop_cnt_d;

  // Counts handshakes only; flush leaves it untouched and it wraps freely.
  assign pop_cnt_d = pop ? pop_cnt_q + 32'd1 : pop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_cnt_q <= '0;
    else        pop_cnt_q <= pop_cnt_d;
  end

  assign pop_cnt = pop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// Bench for fifo_rd_port: memory/fifo_ctrl model, queue-based reference model and directed scenarios.
module tb_fifo_rd_port;

  localparam int DW    = 32;
  localparam int MEM_N = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_oen;
  logic [DW-1:0] mem_rdata;
  logic          flush;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   pop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [MEM_N];
  int wr_ptr = 0;
  int rd_ptr = 0;

  fifo_rd_port #(.DATA_WID(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_oen   (fifo_oen),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_dat    (out_dat)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_cnt    (pop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // fifo_ctrl + synchronous-read memory: empty follows the pointers, data one cycle after oen.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_oen) begin
      mem_rdata <= mem[rd_ptr % MEM_N];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      mem_rdata <= $urandom;
    end
  end

  // Reference model: every word read from memory is owed to the stream two cycles later, in order.
  typedef struct {
    logic [DW-1:0] d;
    int            avail;
  } ent_t;

  ent_t exp_q[$];
  int   cyc = 0;

  always @(negedge clk) begin
    logic exp_vld;
    logic exp_oen;
    cyc++;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      checks++;
      if (fifo_oen !== 1'b0 || out_vld !== 1'b0) begin
        errors++;
        $display("FAIL mon_reset cyc=%0d: oen=%b vld=%b required 0 0", cyc, fifo_oen, out_vld);
      end
    end else begin
      exp_vld = 1'b0;
      if (exp_q.size() > 0) exp_vld = (exp_q[0].avail <= cyc);
      exp_oen = !fifo_empty && !flush && (exp_q.size() < 2 || (exp_vld && out_rdy));
      checks++;
      if (out_vld !== exp_vld) begin
        errors++;
        $display("FAIL mon_vld cyc=%0d: out_vld=%b required %b", cyc, out_vld, exp_vld);
      end
      if (exp_vld) begin
        checks++;
        if (out_dat !== exp_q[0].d) begin
          errors++;
          $display("FAIL mon_dat cyc=%0d: out_dat=%h required %h", cyc, out_dat, exp_q[0].d);
        end
      end
      checks++;
      if (fifo_oen !== exp_oen) begin
        errors++;
        $display("FAIL mon_oen cyc=%0d: fifo_oen=%b required %b", cyc, fifo_oen, exp_oen);
      end
      if (exp_vld && out_rdy) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      if (exp_oen) exp_q.push_back('{d: mem[rd_ptr % MEM_N], avail: cyc + 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d);
    mem[wr_ptr % MEM_N] = d;
    wr_ptr++;
  endtask

  task automatic drain();
    int n = 0;
    out_rdy = 1'b1;
    flush   = 1'b0;
    while ((!fifo_empty || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout: cycles=%0d required <100 (left=%0d)", n, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    flush   = 1'b0;
    out_rdy = 1'b0;
    load(32'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_oen !== 1'b0) begin
        errors++;
        $display("FAIL reset_oen: fifo_oen=%b required 0", fifo_oen);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (out_vld !== 1'b0 || out_dat !== '0) begin
      errors++;
      $display("FAIL reset_out: out_vld=%b out_dat=%h required 0 00000000", out_vld, out_dat);
    end
    drain();
  endtask

  task automatic test_single_word();
    out_rdy = 1'b1;
    load(32'hA5A5_A5A5);
    @(negedge clk);
    checks++;
    if (fifo_oen !== 1'b1) begin
      errors++;
      $display("FAIL single_oen: fifo_oen=%b required 1", fifo_oen);
    end
    @(negedge clk);
    checks++;
    if (fifo_oen !== 1'b0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: oen=%b vld=%b required 0 0", fifo_oen, out_vld);
    end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b1 || out_dat !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL single_n2: vld=%b dat=%h required 1 a5a5a5a5", out_vld, out_dat);
    end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_n3: out_vld=%b required 0", out_vld);
    end
    tick();
  endtask

  task automatic test_stream();
    logic          e_oen, e_vld;
    logic [DW-1:0] e_dat;
    out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) load(DW'(i));
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      e_oen = (k < 8);
      e_vld = (k >= 2 && k <= 9);
      e_dat = DW'(k - 1);
      checks++;
      if (fifo_oen !== e_oen || out_vld !== e_vld || (e_vld && out_dat !== e_dat)) begin
        errors++;
        $display("FAIL stream k=%0d: oen=%b vld=%b dat=%h required %b %b %h",
                 k, fifo_oen, out_vld, out_dat, e_oen, e_vld, e_dat);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n_oen = 0;
    int got   = 0;
    out_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) load(DW'(i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fifo_oen) n_oen++;
      if (k >= 2) begin
        checks++;
        if (out_vld !== 1'b1 || out_dat !== DW'(1)) begin
          errors++;
          $display("FAIL bp_hold k=%0d: vld=%b dat=%h required 1 00000001", k, out_vld, out_dat);
        end
      end
    end
    checks++;
    if (n_oen != 2) begin
      errors++;
      $display("FAIL bp_oen_count: pulses=%0d required 2", n_oen);
    end
    tick();
    out_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (out_dat !== DW'(got + 1)) begin
          errors++;
          $display("FAIL bp_order: out_dat=%h required %h", out_dat, DW'(got + 1));
        end
        got++;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL bp_count: words=%0d required 4", got);
    end
    tick();
  endtask

  task automatic test_flush();
    int got = 0;
    out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) load(DW'(i));
    repeat (5) @(negedge clk);
    tick();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_oen !== 1'b0) begin
      errors++;
      $display("FAIL flush_oen: fifo_oen=%b required 0", fifo_oen);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_vld: out_vld=%b required 0", out_vld);
    end
    tick();
    out_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        checks++;
        if (out_dat !== DW'(got + 4)) begin
          errors++;
          $display("FAIL flush_next: out_dat=%h required %h", out_dat, DW'(got + 4));
        end
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL flush_count: words=%0d required 3", got);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) load($urandom);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0 || out_dat !== '0 || fifo_oen !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: vld=%b dat=%h oen=%b required 0 00000000 0",
               out_vld, out_dat, fifo_oen);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_random();
    int pops = 0;
    for (int k = 0; k < 1500; k++) begin
      tick();
      out_rdy = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) == 0) load($urandom);
      @(negedge clk);
      if (out_vld && out_rdy) pops++;
    end
    checks++;
    if (pops < 100) begin
      errors++;
      $display("FAIL random_pops: handshakes=%0d required >=100", pops);
    end
    flush = 1'b0;
    drain();
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    checks++;
    if (pop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: pop_cnt=%0d required 0", pop_cnt);
    end
    for (int i = 0; i < 5; i++) load($urandom);
    drain();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) load($urandom);
    drain();
    checks++;
    if (pop_cnt !== 32'd7) begin
      errors++;
      $display("FAIL stats_count: pop_cnt=%0d required 7", pop_cnt);
    end
    out_rdy = 1'b0;
    load($urandom);
    repeat (3) @(negedge clk);
    tick();
    force dut.pop_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.pop_cnt_q;
    checks++;
    if (pop_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stats_preload: pop_cnt=%h required ffffffff", pop_cnt);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_wrap: pop_cnt=%h required 00000000", pop_cnt);
    end
    drain();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
